// File: rtl/vehicle_status_monitor_pkg.sv
// vehicle_status_pkg: shared trip state type and default widths/thresholds.
package vehicle_status_pkg;
  typedef enum logic [1:0] {IDLE, DRIVING, ARRIVED} trip_state_t;
  localparam int TEMP_W_D   = 8;
  localparam int TEMP_HI_D  = 90;
  localparam int TEMP_LO_D  = 80;
  localparam int DEBOUNCE_D = 3;
  localparam int FUEL_W_D   = 8;
  localparam int DIST_W_D   = 16;
endpackage

// File: rtl/vehicle_status_monitor_if.sv
// vehicle_status_monitor_if: sensor inputs and status flags of the monitor.
interface vehicle_status_monitor_if
  import vehicle_status_pkg::*;
#(
  parameter int TEMP_W = TEMP_W_D,
  parameter int FUEL_W = FUEL_W_D,
  parameter int DIST_W = DIST_W_D
) ();
  logic              temp_valid;
  logic [TEMP_W-1:0] temp;
  logic              fuel_refill;
  logic              fuel_burn;
  logic              dest_load;
  logic [DIST_W-1:0] dest_dist;
  logic              odo_tick;
  logic              cpu_overheated;
  logic              gas_tank_empty;
  logic [FUEL_W-1:0] fuel_level;
  logic              arrived;
  logic [DIST_W-1:0] remaining;
  modport master (
    output temp_valid, temp, fuel_refill, fuel_burn, dest_load, dest_dist, odo_tick,
    input  cpu_overheated, gas_tank_empty, fuel_level, arrived, remaining
  );
  modport slave (
    input  temp_valid, temp, fuel_refill, fuel_burn, dest_load, dest_dist, odo_tick,
    output cpu_overheated, gas_tank_empty, fuel_level, arrived, remaining
  );
endinterface

// File: rtl/vehicle_status_monitor_temp_hysteresis.sv
// temp_hysteresis: debounced overheat flag with separate assert/clear thresholds.
module temp_hysteresis #(
  parameter int TEMP_W   = 8,
  parameter int TEMP_HI  = 90,
  parameter int TEMP_LO  = 80,
  parameter int DEBOUNCE = 3
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              i_temp_valid,
  input  logic [TEMP_W-1:0] i_temp,
  output logic              o_ovh
);
  localparam int CW = DEBOUNCE > 1 ? $clog2(DEBOUNCE) : 1;
  localparam logic [TEMP_W-1:0] HI = TEMP_W'(TEMP_HI);
  localparam logic [TEMP_W-1:0] LO = TEMP_W'(TEMP_LO);
  logic [CW-1:0] r_cnt;
  logic          r_ovh;
  logic          w_qual;
  logic          w_last;
  // the threshold that qualifies a sample depends on which side we are on
  assign w_qual = r_ovh ? (i_temp <= LO) : (i_temp >= HI);
  assign w_last = r_cnt == CW'(DEBOUNCE - 1);
  assign o_ovh  = r_ovh;
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_cnt <= '0;
      r_ovh <= 1'b0;
    end else if (i_temp_valid) begin
      r_cnt <= (w_qual && !w_last) ? r_cnt + CW'(1) : '0;
      r_ovh <= r_ovh ^ (w_qual && w_last);
    end
  end
endmodule

// File: rtl/vehicle_status_monitor.sv
// vehicle_status_monitor: registered overheat, fuel and trip-arrival status flags.
module vehicle_status_monitor
  import vehicle_status_pkg::*;
#(
  parameter int TEMP_W   = TEMP_W_D,
  parameter int TEMP_HI  = TEMP_HI_D,
  parameter int TEMP_LO  = TEMP_LO_D,
  parameter int DEBOUNCE = DEBOUNCE_D,
  parameter int FUEL_W   = FUEL_W_D,
  parameter int DIST_W   = DIST_W_D
) (
  input logic                     clk,
  input logic                     areset,
  vehicle_status_monitor_if.slave bus
);
  trip_state_t       r_state;
  trip_state_t       w_state_n;
  logic [DIST_W-1:0] r_rem;
  logic [DIST_W-1:0] w_rem_n;
  logic [FUEL_W-1:0] r_fuel;
  logic [FUEL_W-1:0] w_fuel_n;
  temp_hysteresis #(
    .TEMP_W(TEMP_W), .TEMP_HI(TEMP_HI), .TEMP_LO(TEMP_LO), .DEBOUNCE(DEBOUNCE)
  ) u_temp (
    .clk(clk),
    .areset(areset),
    .i_temp_valid(bus.temp_valid),
    .i_temp(bus.temp),
    .o_ovh(bus.cpu_overheated)
  );
  assign w_fuel_n = bus.fuel_refill ? '1 :
                    (bus.fuel_burn && r_fuel != '0) ? r_fuel - FUEL_W'(1) : r_fuel;
  // a load always beats a same-cycle tick; ticks only count while driving with fuel
  always_comb begin
    w_state_n = r_state;
    w_rem_n   = r_rem;
    if (bus.dest_load) begin
      w_state_n = bus.dest_dist != '0 ? DRIVING : ARRIVED;
      w_rem_n   = bus.dest_dist;
    end else if (r_state == DRIVING && bus.odo_tick && r_fuel != '0) begin
      w_state_n = r_rem == DIST_W'(1) ? ARRIVED : DRIVING;
      w_rem_n   = r_rem - DIST_W'(1);
    end
  end
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_fuel  <= '0;
    end else begin
      r_state <= w_state_n;
      r_rem   <= w_rem_n;
      r_fuel  <= w_fuel_n;
    end
  end
  assign bus.fuel_level     = r_fuel;
  assign bus.gas_tank_empty = r_fuel == '0;
  assign bus.arrived        = r_state != DRIVING;
  assign bus.remaining      = r_rem;
endmodule

// File: tb/tb_vehicle_status_monitor.sv
// tb_vehicle_status_monitor: table-driven scoreboard bench for the status monitor.
module tb_vehicle_status_monitor;
  typedef struct {
    logic        tv;
    logic [7:0]  t;
    logic        rf, bn, ld;
    logic [15:0] dd;
    logic        tk;
    logic        ovh;
    logic [7:0]  fuel;
    logic        empty, arr;
    logic [15:0] rem;
  } vec_t;
  typedef struct {
    logic        ovh;
    logic [7:0]  fuel;
    logic        empty, arr;
    logic [15:0] rem;
  } exp_t;

  logic clk = 1'b0;
  logic areset = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  vec_t tbl[$];

  vehicle_status_monitor_if vif ();
  vehicle_status_monitor dut (.clk(clk), .areset(areset), .bus(vif));

  always #5 clk = ~clk;

  function automatic vec_t mk(logic tv, logic [7:0] t, logic rf, logic bn, logic ld,
                              logic [15:0] dd, logic tk, logic ovh, logic [7:0] fuel,
                              logic empty, logic arr, logic [15:0] rem);
    vec_t v;
    v.tv = tv; v.t = t; v.rf = rf; v.bn = bn; v.ld = ld; v.dd = dd; v.tk = tk;
    v.ovh = ovh; v.fuel = fuel; v.empty = empty; v.arr = arr; v.rem = rem;
    return v;
  endfunction

  function automatic vec_t tr(logic [7:0] t, logic ovh);
    return mk(1, t, 0, 0, 0, 0, 0, ovh, 0, 1, 1, 0);
  endfunction

  task automatic cmp(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_all(string tag, exp_t e);
    cmp($sformatf("%s ovh", tag), vif.cpu_overheated, e.ovh);
    cmp($sformatf("%s fuel", tag), vif.fuel_level, e.fuel);
    cmp($sformatf("%s empty", tag), vif.gas_tank_empty, e.empty);
    cmp($sformatf("%s arrived", tag), vif.arrived, e.arr);
    cmp($sformatf("%s remaining", tag), vif.remaining, e.rem);
  endtask

  task automatic step(string tag, vec_t v);
    exp_t e;
    vif.temp_valid = v.tv; vif.temp = v.t; vif.fuel_refill = v.rf; vif.fuel_burn = v.bn;
    vif.dest_load = v.ld; vif.dest_dist = v.dd; vif.odo_tick = v.tk;
    e.ovh = v.ovh; e.fuel = v.fuel; e.empty = v.empty; e.arr = v.arr; e.rem = v.rem;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_all(tag, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t rst_e;
    rst_e.ovh = 0; rst_e.fuel = 0; rst_e.empty = 1; rst_e.arr = 1; rst_e.rem = 0;
    vif.temp_valid = 0; vif.temp = 0; vif.fuel_refill = 0; vif.fuel_burn = 0;
    vif.dest_load = 0; vif.dest_dist = 0; vif.odo_tick = 0;
    // temperature: debounce restart, in-band hold, hysteresis, valid gating
    tbl.push_back(tr(95, 0)); tbl.push_back(tr(95, 0)); tbl.push_back(tr(85, 0));
    tbl.push_back(tr(95, 0)); tbl.push_back(tr(95, 0)); tbl.push_back(tr(95, 1));
    for (int i = 0; i < 5; i++) tbl.push_back(tr(85, 1));
    tbl.push_back(tr(80, 1)); tbl.push_back(tr(79, 1)); tbl.push_back(tr(70, 0));
    tbl.push_back(tr(95, 0)); tbl.push_back(tr(95, 0));
    tbl.push_back(mk(0, 70, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(tr(95, 1));
    tbl.push_back(tr(70, 1)); tbl.push_back(tr(70, 1)); tbl.push_back(tr(70, 0));
    // fuel and trip
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 255, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3, 0, 0, 255, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 255, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 255, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 255, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 255, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 255, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 10, 1, 0, 255, 0, 0, 10));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 255, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 255, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 254, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 255, 0, 1, 0));

    @(negedge clk);
    @(negedge clk);
    #1;
    check_all("reset", rst_e);
    @(negedge clk);
    areset = 0;

    foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i]);

    // drain the tank mid-trip, then ticks must not move remaining
    step("load4", mk(0, 0, 0, 0, 1, 4, 0, 0, 255, 0, 0, 4));
    step("tick4", mk(0, 0, 0, 0, 0, 0, 1, 0, 255, 0, 0, 3));
    for (int k = 1; k <= 255; k++)
      step($sformatf("burn%0d", k), mk(0, 0, 0, 1, 0, 0, 0, 0, 8'(255 - k), (k == 255), 0, 3));
    step("burn_sat", mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 3));
    for (int k = 0; k < 5; k++)
      step($sformatf("tick_empty%0d", k), mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 3));
    step("refill2", mk(0, 0, 1, 0, 0, 0, 0, 0, 255, 0, 0, 3));
    step("tick_refilled", mk(0, 0, 0, 0, 0, 0, 1, 0, 255, 0, 0, 2));

    // asynchronous reset while driving with a partial debounce count
    step("load7", mk(0, 0, 0, 0, 1, 7, 0, 0, 255, 0, 0, 7));
    step("pre95a", mk(1, 95, 0, 0, 0, 0, 0, 0, 255, 0, 0, 7));
    step("pre95b", mk(1, 95, 0, 0, 0, 0, 0, 0, 255, 0, 0, 7));
    vif.temp_valid = 0;
    #2 areset = 1;
    #1;
    check_all("async_reset", rst_e);
    @(negedge clk);
    areset = 0;
    step("post95a", tr(95, 0));
    step("post95b", tr(95, 0));
    step("post95c", tr(95, 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
